player_sprite_animator: RTL

Parametrised player sprite address generator with multi-frame walk animation. It sits between the player position/motion logic and the sprite ROM. Per pixel it flags whether the current draw position lies inside the player's bounding box and produces the ROM address of the matching texel. A frame-synchronous sequencer steps through NUM_FRAMES walk poses while the player moves and selects the left or right facing bank.

---
 rtl/sprite_pkg.sv | 18 +
 rtl/anim_frame_sequencer.sv | 77 +++++++
 rtl/player_sprite_animator.sv | 98 +++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the player sprite pipeline.
package sprite_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

    localparam int PLAYER_W      = 28;
    localparam int PLAYER_H      = 92;
    localparam int PLAYER_FRAMES = 4;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/anim_frame_sequencer.sv
// Walk-pose sequencer: latches motion and direction once per screen frame.
module anim_frame_sequencer
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = PLAYER_FRAMES,
    parameter int HOLD       = 6,
    parameter int FW         = clog2_min1(NUM_FRAMES),
    parameter int HW         = clog2_min1(HOLD)
) (
    input  logic          frame_Clk,
    input  logic          Reset,
    input  logic          fs_i,
    input  logic          moving_i,
    input  logic          dir_i,
    output anim_state_t   state_o,
    output logic [FW-1:0] frame_o,
    output logic [FW-1:0] frame_nx_o,
    output logic          dir_nx_o
);

    localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);

    anim_state_t   state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          dir_q, dir_d;

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        if (fs_i) begin
            dir_d = dir_i;
            unique case (state_q)
                IDLE: begin
                    if (moving_i)
                        state_d = WALK;
                end
                WALK: begin
                    if (!moving_i) begin
                        state_d = IDLE;
                        frame_d = '0;
                        hold_d  = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
                    end else begin
                        hold_d  = hold_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign state_o    = state_q;
    assign frame_o    = frame_q;
    assign frame_nx_o = frame_d;
    assign dir_nx_o   = dir_d;

endmodule

// File: rtl/player_sprite_animator.sv
// Player bounding-box test and sprite ROM address generation.
module player_sprite_animator
    import sprite_pkg::*;
#(
    parameter int SPR_W      = PLAYER_W,
    parameter int SPR_H      = PLAYER_H,
    parameter int NUM_FRAMES = PLAYER_FRAMES,
    parameter int HOLD       = 6,
    parameter int BASE       = 0,
    parameter int DIR_STRIDE = SPR_W * SPR_H * NUM_FRAMES,
    parameter int ADDR_W     = 21
) (
    input  logic                                frame_Clk,
    input  logic                                Reset,
    input  logic                                moving,
    input  logic                                playerDirection,
    input  logic [9:0]                          DrawX,
    input  logic [9:0]                          DrawY,
    input  logic [9:0]                          PlayerX,
    input  logic [9:0]                          PlayerY,
    output logic                                playerOn,
    output logic [ADDR_W-1:0]                   spriteAddress,
    output logic [clog2_min1(NUM_FRAMES)-1:0]   animFrame
);

    localparam int FW = clog2_min1(NUM_FRAMES);

    anim_state_t   anim_state;
    logic [FW-1:0] frame_cur, frame_nx;
    logic          dir_nx;
    logic          fs;

    assign fs = (DrawX == 10'd0) && (DrawY == 10'd0);

    anim_frame_sequencer #(
        .NUM_FRAMES (NUM_FRAMES),
        .HOLD       (HOLD)
    ) u_seq (
        .frame_Clk  (frame_Clk),
        .Reset      (Reset),
        .fs_i       (fs),
        .moving_i   (moving),
        .dir_i      (playerDirection),
        .state_o    (anim_state),
        .frame_o    (frame_cur),
        .frame_nx_o (frame_nx),
        .dir_nx_o   (dir_nx)
    );

    // 11-bit bounds so a sprite near the right/bottom edge never wraps.
    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic        in_box;

    assign x_lo   = {1'b0, PlayerX};
    assign y_lo   = {1'b0, PlayerY};
    assign x_hi   = x_lo + 11'(SPR_W);
    assign y_hi   = y_lo + 11'(SPR_H);
    assign in_box = ({1'b0, DrawX} >= x_lo) && ({1'b0, DrawX} < x_hi)
                 && ({1'b0, DrawY} >= y_lo) && ({1'b0, DrawY} < y_hi);

    logic [9:0]  dx, dy;
    logic [31:0] addr_full;

    assign dx = DrawX - PlayerX;
    assign dy = DrawY - PlayerY;

    // Uses next-state dir/frame so the frame-start pixel sees the new pose.
    assign addr_full = 32'(BASE)
                     + (dir_nx ? 32'(DIR_STRIDE) : 32'd0)
                     + 32'(frame_nx) * 32'(SPR_W * SPR_H)
                     + 32'(dy) * 32'(SPR_W)
                     + 32'(dx);

    logic              on_q, on_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        on_d   = in_box;
        addr_d = addr_q;
        if (in_box)
            addr_d = addr_full[ADDR_W-1:0];
    end

    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            on_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            on_q   <= on_d;
            addr_q <= addr_d;
        end
    end

    assign playerOn      = on_q;
    assign spriteAddress = addr_q;
    assign animFrame     = (anim_state == WALK) ? frame_cur : '0;

endmodule
